// File: rtl/apb_master_bridge_if.sv
// Request-side and two-slave APB bus signals of apb_master_bridge, bundled for port use.
// master = bridge view, slave = requester/slave-model view.
interface apb_master_bridge_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          transfer;
    logic          READ_WRITE;
    logic [AW-1:0] apb_read_paddr;
    logic [AW-1:0] apb_write_paddr;
    logic [DW-1:0] apb_write_data;
    logic [DW-1:0] apb_read_data_out;
    logic          psel1;
    logic          psel2;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready1;
    logic          pready2;
    logic [DW-1:0] prdata1;
    logic [DW-1:0] prdata2;
    logic          pslverr_out;

    modport master (
        input  transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data,
        input  pready1, pready2, prdata1, prdata2,
        output apb_read_data_out, psel1, psel2, penable, pwrite, paddr, pwdata, pslverr_out
    );

    modport slave (
        output transfer, READ_WRITE, apb_read_paddr, apb_write_paddr, apb_write_data,
        output pready1, pready2, prdata1, prdata2,
        input  apb_read_data_out, psel1, psel2, penable, pwrite, paddr, pwdata, pslverr_out
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master bridge: IDLE/SETUP/ACCESS FSM driving two slaves decoded by paddr MSB.
// Optional ACCESS wait timeout with pslverr_out pulse when APB_TIMEOUT_EN is defined.
module apb_master_bridge #(
    parameter int          AW       = 9,
    parameter int          DW       = 8,
    parameter int unsigned MAX_WAIT = 15
) (
    input logic                 pclk,
    input logic                 preset,
    apb_master_bridge_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("MAX_WAIT must be at least 1");
    end

    state_e        state_q, state_d;
    logic [AW-1:0] paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          psel1_q, psel1_d;
    logic          psel2_q, psel2_d;
    logic          penable_q, penable_d;
    logic          pslverr_q, pslverr_d;
    logic          pready_sel;
    logic [DW-1:0] prdata_sel;
    logic          capture;
    logic          timeout;

    always_comb begin
        pready_sel = paddr_q[AW-1] ? bus.pready2 : bus.pready1;
        prdata_sel = paddr_q[AW-1] ? bus.prdata2 : bus.prdata1;
    end

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    // Fires on the wait cycle whose increment would make the count reach MAX_WAIT.
    always_comb begin
        timeout    = (state_q == ACCESS) && !pready_sel &&
                     ((32'(wait_cnt_q) + 32'd1) == MAX_WAIT);
        wait_cnt_d = wait_cnt_q;
        if (state_q == SETUP) begin
            wait_cnt_d = '0;
        end else if ((state_q == ACCESS) && !pready_sel) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    always_comb begin
        timeout = 1'b0;
    end
`endif

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        pslverr_d = 1'b0;
        capture   = 1'b0;

        case (state_q)
            IDLE: begin
                capture = bus.transfer;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (timeout) begin
                    state_d   = IDLE;
                    pslverr_d = 1'b1;
                end else if (pready_sel) begin
                    if (!pwrite_q) begin
                        rdata_d = prdata_sel;
                    end
                    state_d = IDLE;
                    capture = bus.transfer;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            state_d  = SETUP;
            paddr_d  = bus.READ_WRITE ? bus.apb_read_paddr : bus.apb_write_paddr;
            pwrite_d = ~bus.READ_WRITE;
            if (!bus.READ_WRITE) begin
                pwdata_d = bus.apb_write_data;
            end
        end

        // Selects are decoded from next-state values so they stay registered outputs.
        psel1_d   = (state_d != IDLE) && !paddr_d[AW-1];
        psel2_d   = (state_d != IDLE) && paddr_d[AW-1];
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            psel1_q   <= psel1_d;
            psel2_q   <= psel2_d;
            penable_q <= penable_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign bus.apb_read_data_out = rdata_q;
    assign bus.psel1             = psel1_q;
    assign bus.psel2             = psel2_q;
    assign bus.penable           = penable_q;
    assign bus.pwrite            = pwrite_q;
    assign bus.paddr             = paddr_q;
    assign bus.pwdata            = pwdata_q;
    assign bus.pslverr_out       = pslverr_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: transaction lists expanded into per-cycle
// vector tables from the protocol rules, plus hand-written reset and stuck-slave sequences.
module tb_apb_master_bridge;
    localparam int          AW       = 9;
    localparam int          DW       = 8;
    localparam int unsigned MAX_WAIT = 15;

    logic pclk = 1'b0;
    logic preset;

    apb_master_bridge_if #(.AW(AW), .DW(DW)) bus ();

    apb_master_bridge #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .pclk   (pclk),
        .preset (preset),
        .bus    (bus)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic          psel1;
        logic          psel2;
        logic          penable;
        logic          pwrite;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwdata;
        logic [DW-1:0] rdata;
        logic          slverr;
    } out_t;

    typedef struct packed {
        logic          transfer;
        logic          rw;
        logic [AW-1:0] raddr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          pready1;
        logic          pready2;
        logic [DW-1:0] prdata1;
        logic [DW-1:0] prdata2;
    } in_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } cyc_t;

    typedef struct {
        bit            rw;     // 1 = read
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // write data, or data the slave returns on a read
        int unsigned   waits;
        int unsigned   gap;
        bit            b2b;
    } txn_t;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    cyc_t tl[$];
    txn_t txl[$];

    // Architectural view of the bus as the protocol defines it
    logic [AW-1:0] m_paddr  = '0;
    logic          m_pwrite = 1'b0;
    logic [DW-1:0] m_pwdata = '0;
    logic [DW-1:0] m_rdata  = '0;

    function automatic out_t mk_exp(int phase, logic err);
        out_t e;
        e.psel1   = (phase != 0) && !m_paddr[AW-1];
        e.psel2   = (phase != 0) && m_paddr[AW-1];
        e.penable = (phase == 2);
        e.pwrite  = m_pwrite;
        e.paddr   = m_paddr;
        e.pwdata  = m_pwdata;
        e.rdata   = m_rdata;
        e.slverr  = err;
        return e;
    endfunction

    function automatic in_t rand_in();
        in_t r;
        r.transfer = 1'($urandom);
        r.rw       = 1'($urandom);
        r.raddr    = AW'($urandom);
        r.waddr    = AW'($urandom);
        r.wdata    = DW'($urandom);
        r.pready1  = 1'($urandom);
        r.pready2  = 1'($urandom);
        r.prdata1  = DW'($urandom);
        r.prdata2  = DW'($urandom);
        return r;
    endfunction

    function automatic in_t idle_in();
        in_t r = rand_in();
        r.transfer = 1'b0;
        return r;
    endfunction

    function automatic in_t req_in(txn_t t);
        in_t r = rand_in();
        r.transfer = 1'b1;
        r.rw       = t.rw;
        if (t.rw) r.raddr = t.addr;
        else begin
            r.waddr = t.addr;
            r.wdata = t.data;
        end
        return r;
    endfunction

    function automatic in_t with_slave(in_t x, logic [AW-1:0] addr, logic rdy, logic [DW-1:0] dat);
        in_t r = x;
        if (addr[AW-1]) begin
            r.pready2 = rdy;
            r.prdata2 = dat;
        end else begin
            r.pready1 = rdy;
            r.prdata1 = dat;
        end
        return r;
    endfunction

    task automatic push(in_t i, out_t e);
        cyc_t c;
        c.in  = i;
        c.exp = e;
        tl.push_back(c);
    endtask

    // Expand a transaction list into per-cycle inputs and expected outputs.
    task automatic build(txn_t tx[$]);
        for (int i = 0; i < tx.size(); i++) begin
            txn_t t = tx[i];
            in_t  x;
            if (i == 0 || !t.b2b) begin
                for (int unsigned g = 0; g < t.gap; g++) push(idle_in(), mk_exp(0, 1'b0));
                push(req_in(t), mk_exp(0, 1'b0));
            end
            m_paddr  = t.addr;
            m_pwrite = !t.rw;
            if (!t.rw) m_pwdata = t.data;
            push(rand_in(), mk_exp(1, 1'b0));
            for (int unsigned w = 0; w < t.waits; w++) begin
                push(with_slave(rand_in(), t.addr, 1'b0, DW'($urandom)), mk_exp(2, 1'b0));
            end
            if (i + 1 < tx.size() && tx[i+1].b2b) x = req_in(tx[i+1]);
            else x = idle_in();
            push(with_slave(x, t.addr, 1'b1, t.rw ? t.data : DW'($urandom)), mk_exp(2, 1'b0));
            if (t.rw) m_rdata = t.data;
        end
        push(idle_in(), mk_exp(0, 1'b0));
        push(idle_in(), mk_exp(0, 1'b0));
    endtask

    task automatic drive(in_t i);
        bus.transfer        = i.transfer;
        bus.READ_WRITE      = i.rw;
        bus.apb_read_paddr  = i.raddr;
        bus.apb_write_paddr = i.waddr;
        bus.apb_write_data  = i.wdata;
        bus.pready1         = i.pready1;
        bus.pready2         = i.pready2;
        bus.prdata1         = i.prdata1;
        bus.prdata2         = i.prdata2;
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(string name, out_t exp);
        out_t act;
        act = {bus.psel1, bus.psel2, bus.penable, bus.pwrite, bus.paddr,
               bus.pwdata, bus.apb_read_data_out, bus.pslverr_out};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got psel1=%b psel2=%b penable=%b pwrite=%b paddr=%h pwdata=%h rdata=%h slverr=%b, expected psel1=%b psel2=%b penable=%b pwrite=%b paddr=%h pwdata=%h rdata=%h slverr=%b",
                     name, act.psel1, act.psel2, act.penable, act.pwrite, act.paddr, act.pwdata,
                     act.rdata, act.slverr, exp.psel1, exp.psel2, exp.penable, exp.pwrite,
                     exp.paddr, exp.pwdata, exp.rdata, exp.slverr);
        end
    endtask

    task automatic run_table(string tag);
        for (int k = 0; k < tl.size(); k++) begin
            check($sformatf("%s_cyc%0d", tag, k), tl[k].exp);
            drive(tl[k].in);
            step();
        end
        tl.delete();
    endtask

    initial begin
        in_t i;
        txn_t t;

        txl.push_back('{rw:1'b0, addr:9'h012, data:8'h5A, waits:0, gap:1, b2b:1'b0});
        txl.push_back('{rw:1'b1, addr:9'h105, data:8'hC3, waits:3, gap:1, b2b:1'b0});
        txl.push_back('{rw:1'b0, addr:9'h00A, data:8'h11, waits:0, gap:1, b2b:1'b0});
        txl.push_back('{rw:1'b1, addr:9'h10A, data:8'h3C, waits:1, gap:0, b2b:1'b1});
        txl.push_back('{rw:1'b1, addr:9'h020, data:8'h77, waits:0, gap:2, b2b:1'b0});
        txl.push_back('{rw:1'b0, addr:9'h150, data:8'h99, waits:2, gap:0, b2b:1'b1});
        txl.push_back('{rw:1'b0, addr:9'h1FF, data:8'hA5, waits:0, gap:0, b2b:1'b1});

        preset = 1'b1;
        drive(rand_in());
        repeat (2) @(posedge pclk);
        #1;
        check("reset", mk_exp(0, 1'b0));
        preset = 1'b0;

        build(txl);
        run_table("dir");

        txl.delete();
        for (int n = 0; n < 40; n++) begin
            t.rw    = 1'($urandom);
            t.addr  = AW'($urandom);
            t.data  = DW'($urandom);
            t.waits = $urandom_range(0, 4);
            t.gap   = $urandom_range(0, 2);
            t.b2b   = 1'($urandom);
            txl.push_back(t);
        end
        build(txl);
        run_table("rnd");

        // Reset lands in ACCESS of a read whose slave is ready with 0xFF.
        i = idle_in();
        i.transfer = 1'b1;
        i.rw       = 1'b1;
        i.raddr    = 9'h034;
        i.pready1  = 1'b0;
        drive(i);
        step();
        m_paddr  = 9'h034;
        m_pwrite = 1'b0;
        check("rst_setup", mk_exp(1, 1'b0));
        i.transfer = 1'b0;
        drive(i);
        step();
        check("rst_access", mk_exp(2, 1'b0));
        i.pready1 = 1'b1;
        i.prdata1 = 8'hFF;
        drive(i);
        preset = 1'b1;
        step();
        m_paddr  = '0;
        m_pwrite = 1'b0;
        m_pwdata = '0;
        m_rdata  = '0;
        check("rst_mid", mk_exp(0, 1'b0));
        preset = 1'b0;
        step();
        check("rst_after", mk_exp(0, 1'b0));

        // Slave 1 never ready; slave 2's ready must be ignored; request kept pending.
        i = idle_in();
        i.transfer = 1'b1;
        i.rw       = 1'b1;
        i.raddr    = 9'h0F0;
        i.pready1  = 1'b0;
        i.pready2  = 1'b1;
        drive(i);
        step();
        m_paddr  = 9'h0F0;
        m_pwrite = 1'b0;
        check("stuck_setup", mk_exp(1, 1'b0));
        step();
        for (int unsigned k = 1; k <= MAX_WAIT; k++) begin
            check($sformatf("stuck_acc%0d", k), mk_exp(2, 1'b0));
            step();
        end
`ifdef APB_TIMEOUT_EN
        check("timeout_pulse", mk_exp(0, 1'b1));
        step();
        check("timeout_retake", mk_exp(1, 1'b0));
        i.transfer = 1'b0;
        i.pready1  = 1'b1;
        i.prdata1  = 8'h42;
        drive(i);
        step();
        check("timeout_retry_acc", mk_exp(2, 1'b0));
        step();
        m_rdata = 8'h42;
        check("timeout_retry_done", mk_exp(0, 1'b0));
`else
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stuck_late%0d", k), mk_exp(2, 1'b0));
            step();
        end
        check("stuck_last", mk_exp(2, 1'b0));
        i.transfer = 1'b0;
        i.pready1  = 1'b1;
        i.prdata1  = 8'h42;
        drive(i);
        step();
        m_rdata = 8'h42;
        check("stuck_done", mk_exp(0, 1'b0));
`endif
        step();
        check("final_idle", mk_exp(0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
